// File: rtl/fifo_pkg.sv
// Definitions shared by the burst writer and the write-side FIFO: state encoding
// and default widths.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_LEN_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2,
    ST_STALL = 2'd3
  } wr_state_e;

  // Minimum counter width able to hold max_val, never below one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pace_counter.sv
// Loadable down-counter that pulses done on its last counting cycle; paces the
// idle gap between consecutive FIFO writes.
module pace_counter #(
  parameter int P_CNT_W = 2
) (
  input  logic               PROD_CLK,
  input  logic               RST_n,
  input  logic               load,
  input  logic [P_CNT_W-1:0] load_val,
  input  logic               en,
  output logic               done
);

  logic [P_CNT_W-1:0] cnt_q;

  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - P_CNT_W'(1);
    end
  end

  // Terminal count is 1 so that a load of N yields exactly N enabled cycles.
  assign done = en && (cnt_q == P_CNT_W'(1));

endmodule

// File: rtl/prod_burst_writer.sv
// Producer-side burst writer: moves BURST_LEN source words into a FIFO write
// port with a forced idle gap between writes, honouring FULL and ABORT.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for START with a non-zero BURST_LEN
//   ST_WRITE | ready to accept one source word
//   ST_GAP   | forced idle spacing after a non-final transfer
//   ST_STALL | FIFO full, waiting for FULL to drop
module prod_burst_writer
  import fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH  = FIFO_DATA_WIDTH,
  parameter int P_IDLE_CYCLES = 2,
  parameter int P_LEN_W       = FIFO_LEN_W
) (
  input  logic                    PROD_CLK,
  input  logic                    RST_n,
  input  logic                    START,
  input  logic [P_LEN_W-1:0]      BURST_LEN,
  input  logic                    ABORT,
  input  logic                    SRC_VALID,
  input  logic [P_DATA_WIDTH-1:0] SRC_DATA,
  output logic                    SRC_READY,
  input  logic                    FULL,
  output logic                    W_EN,
  output logic [P_DATA_WIDTH-1:0] DATA_IN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [P_LEN_W-1:0]      WORDS_WRITTEN
);

  localparam int                 GAP_W    = cnt_width(P_IDLE_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(P_IDLE_CYCLES);
  localparam logic [P_LEN_W-1:0] LEN_ONE  = P_LEN_W'(1);
  localparam logic [P_LEN_W-1:0] LEN_MAX  = '1;

  wr_state_e state_q, state_d;

  logic [P_LEN_W-1:0]      remaining_q;
  logic [P_LEN_W-1:0]      words_q;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    w_en_q;
  logic                    done_q;

  logic start_ok;
  logic xfer;
  logic last_word;
  logic gap_load;
  logic gap_done;

  assign start_ok  = (state_q == ST_IDLE) && START && (BURST_LEN != '0);
  assign SRC_READY = (state_q == ST_WRITE) && !FULL && !ABORT;
  assign xfer      = SRC_READY && SRC_VALID;
  assign last_word = (remaining_q == LEN_ONE);

  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (FULL) begin
          state_d = ST_STALL;
        end else if (SRC_VALID) begin
          if (last_word) begin
            state_d = ST_IDLE;
          end else if (P_IDLE_CYCLES == 0) begin
            state_d = ST_WRITE;
          end else begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (ABORT) state_d = ST_IDLE;
        else if (gap_done) state_d = ST_WRITE;
      end
      ST_STALL: begin
        if (ABORT) state_d = ST_IDLE;
        else if (!FULL) state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pace_counter #(
    .P_CNT_W (GAP_W)
  ) u_gap_cnt (
    .PROD_CLK (PROD_CLK),
    .RST_n    (RST_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (state_q == ST_GAP),
    .done     (gap_done)
  );

  // DONE is registered alongside W_EN so both land in the same cycle.
  always_ff @(posedge PROD_CLK or negedge RST_n) begin
    if (!RST_n) begin
      remaining_q <= '0;
      words_q     <= '0;
      data_q      <= '0;
      w_en_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      w_en_q <= xfer;
      done_q <= xfer && last_word;
      if (start_ok) begin
        remaining_q <= BURST_LEN;
        words_q     <= '0;
      end else if (xfer) begin
        remaining_q <= remaining_q - LEN_ONE;
        data_q      <= SRC_DATA;
        if (words_q != LEN_MAX) words_q <= words_q + LEN_ONE;
      end
    end
  end

  assign W_EN          = w_en_q;
  assign DATA_IN       = data_q;
  assign DONE          = done_q;
  assign WORDS_WRITTEN = words_q;
  assign BUSY          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_prod_burst_writer.sv
// Directed bench for prod_burst_writer, including a 333-deep dual-clock FIFO model.
module tb_prod_burst_writer;

  localparam int DW    = 8;
  localparam int LW    = 10;
  localparam int DEPTH = 333;

  logic          PROD_CLK = 1'b0;
  logic          RD_CLK   = 1'b0;
  logic          RST_n    = 1'b0;
  logic          START    = 1'b0;
  logic          ABORT    = 1'b0;
  logic          SRC_VALID = 1'b0;
  logic [LW-1:0] BURST_LEN = '0;
  logic [DW-1:0] src_data = 8'hA0;
  logic          full_force = 1'b0;
  logic          fifo_mode  = 1'b0;
  logic          rd_en      = 1'b0;
  logic [DW-1:0] rd_base    = '0;

  logic          SRC_READY, FULL, W_EN, BUSY, DONE;
  logic [DW-1:0] DATA_IN;
  logic [LW-1:0] WORDS_WRITTEN;

  int checks = 0;
  int failures = 0;

  int wp = 0, rp = 0, overflow = 0, rd_count = 0, rd_err = 0;
  logic [DW-1:0] fifo_mem [DEPTH];

  assign FULL = full_force | (fifo_mode & ((wp - rp) >= DEPTH));

  always #5 PROD_CLK = ~PROD_CLK;
  always #7 RD_CLK   = ~RD_CLK;

  prod_burst_writer #(
    .P_DATA_WIDTH  (DW),
    .P_IDLE_CYCLES (2),
    .P_LEN_W       (LW)
  ) dut (
    .PROD_CLK      (PROD_CLK),
    .RST_n         (RST_n),
    .START         (START),
    .BURST_LEN     (BURST_LEN),
    .ABORT         (ABORT),
    .SRC_VALID     (SRC_VALID),
    .SRC_DATA      (src_data),
    .SRC_READY     (SRC_READY),
    .FULL          (FULL),
    .W_EN          (W_EN),
    .DATA_IN       (DATA_IN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .WORDS_WRITTEN (WORDS_WRITTEN)
  );

  // Source presents an incrementing sequence, advancing on each accepted word.
  always @(posedge PROD_CLK)
    if (SRC_READY && SRC_VALID) src_data <= src_data + 8'd1;

  always @(posedge PROD_CLK)
    if (fifo_mode && W_EN) begin
      if ((wp - rp) >= DEPTH) overflow <= overflow + 1;
      else begin
        fifo_mem[wp % DEPTH] <= DATA_IN;
        wp <= wp + 1;
      end
    end

  always @(posedge RD_CLK)
    if (fifo_mode && rd_en && ((wp - rp) > 0)) begin
      if (fifo_mem[rp % DEPTH] !== 8'(int'(rd_base) + rd_count)) rd_err <= rd_err + 1;
      rd_count <= rd_count + 1;
      rp <= rp + 1;
    end

  task automatic cyc();
    @(posedge PROD_CLK);
    #1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++; if (W_EN !== 1'b0) begin failures++; $display("FAIL reset_w_en got=%b want=0", W_EN); end
    checks++; if (DATA_IN !== 8'h00) begin failures++; $display("FAIL reset_data_in got=%h want=00", DATA_IN); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", DONE); end
    checks++; if (WORDS_WRITTEN !== 10'd0) begin failures++; $display("FAIL reset_words got=%0d want=0", WORDS_WRITTEN); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    // START is already presented when reset lifts; first edge must take it.
    START = 1'b1; BURST_LEN = 10'd3; SRC_VALID = 1'b1;
    #1 RST_n = 1'b1;
    cyc();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL first_start_busy got=%b want=1", BUSY); end
    // ABORT together with a would-be transfer: no word accepted.
    ABORT = 1'b1;
    #1;
    checks++; if (SRC_READY !== 1'b0) begin failures++; $display("FAIL abort_collision_ready got=%b want=0", SRC_READY); end
    cyc();
    ABORT = 1'b0; SRC_VALID = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_collision_busy got=%b want=0", BUSY); end
    checks++; if (W_EN !== 1'b0) begin failures++; $display("FAIL abort_collision_w_en got=%b want=0", W_EN); end
    checks++; if (src_data !== 8'hA0) begin failures++; $display("FAIL abort_collision_src got=%h want=a0", src_data); end
  endtask

  task automatic test_basic_burst();
    logic [DW-1:0] exp;
    int n_wen, n_done, last_k;
    exp = src_data; n_wen = 0; n_done = 0; last_k = -1;
    START = 1'b1; BURST_LEN = 10'd4; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (W_EN) begin
        checks++; if (DATA_IN !== exp) begin failures++; $display("FAIL basic_data got=%h want=%h", DATA_IN, exp); end
        checks++; if (WORDS_WRITTEN !== LW'(n_wen + 1)) begin failures++; $display("FAIL basic_words got=%0d want=%0d", WORDS_WRITTEN, n_wen + 1); end
        if (n_wen > 0) begin
          checks++; if ((k - last_k) !== 3) begin failures++; $display("FAIL basic_period got=%0d want=3", k - last_k); end
        end
        exp = exp + 8'd1; last_k = k; n_wen++;
      end
      if (DONE) begin
        n_done++;
        checks++; if (!(W_EN === 1'b1 && n_wen == 4)) begin failures++; $display("FAIL basic_done_align got w_en=%b words=%0d want w_en=1 words=4", W_EN, n_wen); end
      end
    end
    SRC_VALID = 1'b0;
    checks++; if (n_wen !== 4) begin failures++; $display("FAIL basic_wen_count got=%0d want=4", n_wen); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL basic_done_count got=%0d want=1", n_done); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", BUSY); end
  endtask

  task automatic test_full_stall();
    logic [DW-1:0] exp;
    int n_wen, n_done, full_left;
    exp = src_data; n_wen = 0; n_done = 0; full_left = 0;
    START = 1'b1; BURST_LEN = 10'd6; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (full_force) begin
        checks++; if (W_EN !== 1'b0) begin failures++; $display("FAIL stall_w_en got=%b want=0", W_EN); end
      end
      if (W_EN) begin
        checks++; if (DATA_IN !== exp) begin failures++; $display("FAIL stall_data got=%h want=%h", DATA_IN, exp); end
        exp = exp + 8'd1; n_wen++;
        if (n_wen == 2) full_left = 5;
      end
      if (DONE) n_done++;
      full_force = (full_left > 0);
      if (full_left > 0) full_left--;
      #1;
      if (full_force) begin
        checks++; if (SRC_READY !== 1'b0 || BUSY !== 1'b1) begin failures++; $display("FAIL stall_ready got ready=%b busy=%b want ready=0 busy=1", SRC_READY, BUSY); end
      end
    end
    SRC_VALID = 1'b0; full_force = 1'b0;
    checks++; if (n_wen !== 6) begin failures++; $display("FAIL stall_wen_count got=%0d want=6", n_wen); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL stall_done_count got=%0d want=1", n_done); end
    checks++; if (WORDS_WRITTEN !== 10'd6) begin failures++; $display("FAIL stall_words got=%0d want=6", WORDS_WRITTEN); end
    checks++; if (src_data !== exp) begin failures++; $display("FAIL stall_src_consumed got=%h want=%h", src_data, exp); end
  endtask

  task automatic test_abort();
    logic [DW-1:0] exp;
    int n_wen, n_bad;
    exp = src_data; n_wen = 0; n_bad = 0;
    START = 1'b1; BURST_LEN = 10'd6; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    for (int k = 0; k < 20 && n_wen < 2; k++) begin
      cyc();
      if (W_EN) begin exp = exp + 8'd1; n_wen++; end
    end
    checks++; if (n_wen !== 2) begin failures++; $display("FAIL abort_wait got=%0d want=2", n_wen); end
    ABORT = 1'b1;
    cyc();
    ABORT = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", BUSY); end
    checks++; if (WORDS_WRITTEN !== 10'd2) begin failures++; $display("FAIL abort_words got=%0d want=2", WORDS_WRITTEN); end
    for (int k = 0; k < 8; k++) begin
      if (W_EN !== 1'b0 || DONE !== 1'b0) n_bad++;
      cyc();
    end
    SRC_VALID = 1'b0;
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL abort_quiet got=%0d want=0", n_bad); end
    checks++; if (src_data !== exp) begin failures++; $display("FAIL abort_src_consumed got=%h want=%h", src_data, exp); end
  endtask

  task automatic test_ignored_start();
    int n_wen, n_done;
    n_wen = 0; n_done = 0;
    START = 1'b1; BURST_LEN = 10'd0; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL zero_len_busy got=%b want=0", BUSY); end
    checks++; if (WORDS_WRITTEN !== 10'd2) begin failures++; $display("FAIL zero_len_words got=%0d want=2", WORDS_WRITTEN); end
    SRC_VALID = 1'b0;
    START = 1'b1; BURST_LEN = 10'd2;
    cyc();
    BURST_LEN = 10'd5;
    cyc(); cyc();
    START = 1'b0;
    checks++; if (BUSY !== 1'b1 || WORDS_WRITTEN !== 10'd0) begin failures++; $display("FAIL busy_start got busy=%b words=%0d want busy=1 words=0", BUSY, WORDS_WRITTEN); end
    SRC_VALID = 1'b1;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (W_EN) n_wen++;
      if (DONE) n_done++;
    end
    SRC_VALID = 1'b0;
    checks++; if (n_wen !== 2) begin failures++; $display("FAIL busy_start_wen got=%0d want=2", n_wen); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL busy_start_done got=%0d want=1", n_done); end
  endtask

  task automatic test_reset_in_gap();
    int n_bad;
    n_bad = 0;
    START = 1'b1; BURST_LEN = 10'd4; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    cyc();
    checks++; if (W_EN !== 1'b1) begin failures++; $display("FAIL gap_reset_setup got=%b want=1", W_EN); end
    #1 RST_n = 1'b0;
    #1;
    checks++; if (W_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin failures++; $display("FAIL gap_reset_ctrl got w_en=%b done=%b busy=%b want 0 0 0", W_EN, DONE, BUSY); end
    checks++; if (DATA_IN !== 8'h00 || WORDS_WRITTEN !== 10'd0) begin failures++; $display("FAIL gap_reset_data got data=%h words=%0d want 00 0", DATA_IN, WORDS_WRITTEN); end
    cyc();
    RST_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (W_EN !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) n_bad++;
    end
    SRC_VALID = 1'b0;
    checks++; if (n_bad !== 0) begin failures++; $display("FAIL gap_reset_quiet got=%0d want=0", n_bad); end
  endtask

  task automatic test_fifo_integration();
    int  guard;
    logic full_seen;
    full_seen = 1'b0;
    rd_base = src_data; fifo_mode = 1'b1; rd_en = 1'b0;
    START = 1'b1; BURST_LEN = 10'd20; SRC_VALID = 1'b1;
    cyc();
    START = 1'b0;
    guard = 0;
    while (BUSY && guard < 200) begin cyc(); guard++; end
    cyc();
    START = 1'b1; BURST_LEN = 10'd333;
    cyc();
    START = 1'b0;
    guard = 0;
    while (!FULL && guard < 2000) begin cyc(); guard++; end
    full_seen = FULL;
    checks++; if (full_seen !== 1'b1) begin failures++; $display("FAIL fifo_full_reached got=%b want=1", full_seen); end
    for (int k = 0; k < 10; k++) cyc();
    rd_en = 1'b1;
    guard = 0;
    while (BUSY && guard < 3000) begin cyc(); guard++; end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL fifo_burst_end got busy=%b want=0", BUSY); end
    guard = 0;
    while (rd_count < 353 && guard < 2000) begin cyc(); guard++; end
    SRC_VALID = 1'b0;
    checks++; if (overflow !== 0) begin failures++; $display("FAIL fifo_write_while_full got=%0d want=0", overflow); end
    checks++; if (rd_count !== 353) begin failures++; $display("FAIL fifo_read_count got=%0d want=353", rd_count); end
    checks++; if (rd_err !== 0) begin failures++; $display("FAIL fifo_read_order got=%0d want=0", rd_err); end
    checks++; if (WORDS_WRITTEN !== 10'd333) begin failures++; $display("FAIL fifo_words got=%0d want=333", WORDS_WRITTEN); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_full_stall();
    test_abort();
    test_ignored_start();
    test_reset_in_gap();
    test_fifo_integration();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
